// File: rtl/operand_hud_display.sv
// operand_hud_display: N-channel HUD operand controller.
// Each channel hides for a number of frames after a hit, optionally blinks,
// then returns to visible. The top performs the per-channel pixel region test
// and registers drawing requests plus bitmap offsets for a shared operand ROM.
// Optional feature macro: OPERAND_HUD_BLINK_EN (blink phase after the hide timeout).

// Per-channel visibility sequencer.
//   state      | meaning
//   ST_VISIBLE | operand shown, waiting for a hit
//   ST_HIDDEN  | hide timeout running, cnt frames remain
//   ST_BLINK   | blink phase, shown while blink bit is set (OPERAND_HUD_BLINK_EN only)
module operand_hud_channel #(
    parameter int HIDE_FRAMES  = 450,
    parameter int BLINK_FRAMES = 60,
    parameter int BLINK_PERIOD = 8,
    parameter int CNT_W        = 10
) (
    input  logic clk,
    input  logic resetN,
    input  logic startOfFrame,
    input  logic hit,
    output logic visible
);

    localparam logic [CNT_W-1:0] HIDE_LOAD = CNT_W'(HIDE_FRAMES);

`ifdef OPERAND_HUD_BLINK_EN
    localparam int PH_W = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;
    localparam logic [CNT_W-1:0] BLINK_LOAD = CNT_W'(BLINK_FRAMES);
    localparam logic [PH_W-1:0]  PH_LAST    = PH_W'(BLINK_PERIOD - 1);
`endif

    typedef enum logic [1:0] {
        ST_VISIBLE = 2'd0,
`ifdef OPERAND_HUD_BLINK_EN
        ST_BLINK   = 2'd2,
`endif
        ST_HIDDEN  = 2'd1
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
`ifdef OPERAND_HUD_BLINK_EN
    logic [PH_W-1:0]  phase, phase_n;
    logic             blink, blink_n;
`endif

    // State and frame counters; reset aborts any timeout in progress.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= ST_VISIBLE;
            cnt   <= '0;
`ifdef OPERAND_HUD_BLINK_EN
            phase <= '0;
            blink <= 1'b0;
`endif
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
`ifdef OPERAND_HUD_BLINK_EN
            phase <= phase_n;
            blink <= blink_n;
`endif
        end
    end

    // Next-state logic; a hit always wins over a same-cycle frame tick.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
`ifdef OPERAND_HUD_BLINK_EN
        phase_n = phase;
        blink_n = blink;
`endif
        case (state)
            ST_VISIBLE: begin
                if (hit) begin
                    state_n = ST_HIDDEN;
                    cnt_n   = HIDE_LOAD;
                end
            end
            ST_HIDDEN: begin
                if (hit) begin
                    cnt_n = HIDE_LOAD;
                end else if (startOfFrame) begin
                    if (cnt > CNT_W'(1)) begin
                        cnt_n = cnt - 1'b1;
                    end else begin
`ifdef OPERAND_HUD_BLINK_EN
                        state_n = ST_BLINK;
                        cnt_n   = BLINK_LOAD;
                        phase_n = '0;
                        blink_n = 1'b0;
`else
                        state_n = ST_VISIBLE;
                        cnt_n   = '0;
`endif
                    end
                end
            end
`ifdef OPERAND_HUD_BLINK_EN
            ST_BLINK: begin
                if (hit) begin
                    state_n = ST_HIDDEN;
                    cnt_n   = HIDE_LOAD;
                end else if (startOfFrame) begin
                    if (phase == PH_LAST) begin
                        phase_n = '0;
                        blink_n = ~blink;
                    end else begin
                        phase_n = phase + 1'b1;
                    end
                    if (cnt > CNT_W'(1)) begin
                        cnt_n = cnt - 1'b1;
                    end else begin
                        state_n = ST_VISIBLE;
                        cnt_n   = '0;
                    end
                end
            end
`endif
            default: begin
                state_n = ST_VISIBLE;
                cnt_n   = '0;
            end
        endcase
    end

`ifdef OPERAND_HUD_BLINK_EN
    assign visible = (state == ST_VISIBLE) | ((state == ST_BLINK) & blink);
`else
    assign visible = (state == ST_VISIBLE);
`endif

endmodule

module operand_hud_display #(
    parameter int NUM_OPS      = 4,
    parameter int BASE_X       = 50,
    parameter int BASE_Y       = 430,
    parameter int STRIDE_X     = 200,
    parameter int OBJ_W        = 32,
    parameter int OBJ_H        = 32,
    parameter int HIDE_FRAMES  = 450,
    parameter int BLINK_FRAMES = 60,
    parameter int BLINK_PERIOD = 8,
    parameter int CNT_W        = 10,
    localparam int SEL_W       = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic [10:0]        pixelX,
    input  logic [10:0]        pixelY,
    input  logic               startOfFrame,
    input  logic [NUM_OPS-1:0] hit,
    output logic [NUM_OPS-1:0] operandDR,
    output logic               anyDR,
    output logic [SEL_W-1:0]   selIdx,
    output logic [10:0]        offsetX,
    output logic [10:0]        offsetY,
    output logic [NUM_OPS-1:0] visible
);

    localparam logic [11:0] TOP_Y   = 12'(BASE_Y);
    localparam logic [11:0] BOT_Y   = 12'(BASE_Y + OBJ_H);
    localparam logic [10:0] TOP_Y11 = 11'(BASE_Y);

    logic [NUM_OPS-1:0] vis;
    logic [NUM_OPS-1:0] inside_v;
    logic [NUM_OPS-1:0] req_v;
    logic               y_in;
    logic [SEL_W-1:0]   sel_n;
    logic [10:0]        offx_n;

    // Left edge of a channel in 12-bit space so large strides cannot wrap.
    function automatic logic [11:0] left_edge(input int idx);
        return 12'(BASE_X + idx * STRIDE_X);
    endfunction

    for (genvar g = 0; g < NUM_OPS; g++) begin : g_ch
        operand_hud_channel #(
            .HIDE_FRAMES (HIDE_FRAMES),
            .BLINK_FRAMES(BLINK_FRAMES),
            .BLINK_PERIOD(BLINK_PERIOD),
            .CNT_W       (CNT_W)
        ) u_ch (
            .clk         (clk),
            .resetN      (resetN),
            .startOfFrame(startOfFrame),
            .hit         (hit[g]),
            .visible     (vis[g])
        );
    end

    assign visible = vis;

    // Region test per channel, masked by visibility.
    always_comb begin
        inside_v = '0;
        y_in     = ({1'b0, pixelY} >= TOP_Y) && ({1'b0, pixelY} < BOT_Y);
        for (int i = 0; i < NUM_OPS; i++) begin
            inside_v[i] = y_in
                        && ({1'b0, pixelX} >= left_edge(i))
                        && ({1'b0, pixelX} <  (left_edge(i) + 12'(OBJ_W)));
        end
        req_v = inside_v & vis;
    end

    // Lowest-index requesting channel selects the bitmap offsets.
    always_comb begin
        sel_n  = '0;
        offx_n = '0;
        for (int i = NUM_OPS - 1; i >= 0; i--) begin
            if (req_v[i]) begin
                sel_n  = SEL_W'(i);
                offx_n = 11'({1'b0, pixelX} - left_edge(i));
            end
        end
    end

    // Registered drawing outputs; selection and offsets hold when nothing requests.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            operandDR <= '0;
            anyDR     <= 1'b0;
            selIdx    <= '0;
            offsetX   <= '0;
            offsetY   <= '0;
        end else begin
            operandDR <= req_v;
            anyDR     <= |req_v;
            if (|req_v) begin
                selIdx  <= sel_n;
                offsetX <= offx_n;
                offsetY <= pixelY - TOP_Y11;
            end
        end
    end

endmodule

// File: tb/tb_operand_hud_display.sv
// Directed self-checking bench for operand_hud_display (NUM_OPS=4, short timeouts).
module tb_operand_hud_display;

    localparam int NUM_OPS = 4;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic [10:0] pixelX = '0;
    logic [10:0] pixelY = '0;
    logic        startOfFrame = 1'b0;
    logic [3:0]  hit = '0;
    logic [3:0]  operandDR;
    logic        anyDR;
    logic [1:0]  selIdx;
    logic [10:0] offsetX;
    logic [10:0] offsetY;
    logic [3:0]  visible;

    int checks = 0;
    int passed = 0;

    // Bit k-1 = expected visibility k frames after a hit (until recovery).
    logic [7:0] exp_tab;
    int         rec_frames;

    operand_hud_display #(
        .NUM_OPS     (NUM_OPS),
        .HIDE_FRAMES (4),
        .BLINK_FRAMES(4),
        .BLINK_PERIOD(2),
        .CNT_W       (10)
    ) dut (
        .clk         (clk),
        .resetN      (resetN),
        .pixelX      (pixelX),
        .pixelY      (pixelY),
        .startOfFrame(startOfFrame),
        .hit         (hit),
        .operandDR   (operandDR),
        .anyDR       (anyDR),
        .selIdx      (selIdx),
        .offsetX     (offsetX),
        .offsetY     (offsetY),
        .visible     (visible)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic next_frame();
        tick(99);
        startOfFrame = 1'b1;
        tick(1);
        startOfFrame = 1'b0;
    endtask

    task automatic hit_pulse(input logic [3:0] mask);
        hit = mask;
        tick(1);
        hit = '0;
    endtask

    task automatic set_pixel(input int x, input int y);
        pixelX = 11'(x);
        pixelY = 11'(y);
        tick(1);
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        tick(3);
        checks++; if (visible !== 4'b1111) $display("FAIL reset_visible got=%b exp=1111", visible); else passed++;
        checks++; if (operandDR !== 4'b0000) $display("FAIL reset_dr got=%b exp=0000", operandDR); else passed++;
        checks++; if ({anyDR, selIdx, offsetX, offsetY} !== 25'd0)
            $display("FAIL reset_outs got any=%b sel=%0d ox=%0d oy=%0d exp all 0", anyDR, selIdx, offsetX, offsetY);
        else passed++;
        resetN = 1'b1;
        tick(1);
        pixelX = 11'd60;
        pixelY = 11'd440;
        #1;
        checks++; if (operandDR !== 4'b0000) $display("FAIL dr_latency got=%b exp=0000 before edge", operandDR); else passed++;
        tick(1);
        checks++; if (operandDR !== 4'b0001) $display("FAIL first_pixel_dr got=%b exp=0001", operandDR); else passed++;
        checks++; if (anyDR !== 1'b1) $display("FAIL first_pixel_any got=%b exp=1", anyDR); else passed++;
        checks++; if ({selIdx, offsetX, offsetY} !== {2'd0, 11'd10, 11'd10})
            $display("FAIL first_pixel_sel got sel=%0d ox=%0d oy=%0d exp 0/10/10", selIdx, offsetX, offsetY);
        else passed++;
        set_pixel(0, 0);
        checks++; if ({operandDR, anyDR, selIdx, offsetX, offsetY} !== {4'b0, 1'b0, 2'd0, 11'd10, 11'd10})
            $display("FAIL hold_offsets got dr=%b any=%b sel=%0d ox=%0d oy=%0d exp 0/0/0/10/10",
                     operandDR, anyDR, selIdx, offsetX, offsetY);
        else passed++;
    endtask

    task automatic test_region_edges();
        int          vx  [11] = '{49, 50, 81, 82, 60, 60, 250, 281, 282, 681, 450};
        int          vy  [11] = '{440, 430, 461, 440, 462, 429, 440, 440, 440, 445, 431};
        logic [3:0]  vdr [11] = '{4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000,
                                  4'b0010, 4'b0010, 4'b0000, 4'b1000, 4'b0100};
        logic [1:0]  vsel[11] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd3, 2'd2};
        logic [10:0] vox [11] = '{11'd10, 11'd0, 11'd31, 11'd31, 11'd31, 11'd31, 11'd0, 11'd31, 11'd31, 11'd31, 11'd0};
        logic [10:0] voy [11] = '{11'd10, 11'd0, 11'd31, 11'd31, 11'd31, 11'd31, 11'd10, 11'd10, 11'd10, 11'd15, 11'd1};
        for (int k = 0; k < 11; k++) begin
            set_pixel(vx[k], vy[k]);
            checks++; if ({operandDR, anyDR} !== {vdr[k], |vdr[k]})
                $display("FAIL edge_dr[%0d] (%0d,%0d) got dr=%b any=%b exp dr=%b", k, vx[k], vy[k], operandDR, anyDR, vdr[k]);
            else passed++;
            checks++; if ({selIdx, offsetX, offsetY} !== {vsel[k], vox[k], voy[k]})
                $display("FAIL edge_sel[%0d] got sel=%0d ox=%0d oy=%0d exp %0d/%0d/%0d",
                         k, selIdx, offsetX, offsetY, vsel[k], vox[k], voy[k]);
            else passed++;
        end
        set_pixel(0, 0);
    endtask

    task automatic test_hit_timeout();
        hit_pulse(4'b0010);
        checks++; if (visible !== 4'b1101) $display("FAIL hit_hide got=%b exp=1101", visible); else passed++;
        for (int k = 1; k <= rec_frames; k++) begin
            next_frame();
            checks++; if (visible[1] !== exp_tab[k-1])
                $display("FAIL hit_frame%0d got=%b exp=%b", k, visible[1], exp_tab[k-1]);
            else passed++;
        end
        for (int k = 0; k < 2; k++) begin
            next_frame();
            checks++; if (visible !== 4'b1111) $display("FAIL hit_stays_visible got=%b exp=1111", visible); else passed++;
        end
    endtask

    task automatic test_rearm();
        hit_pulse(4'b0010);
        next_frame();
        next_frame();
        checks++; if (visible[1] !== 1'b0) $display("FAIL rearm_pre got=%b exp=0", visible[1]); else passed++;
        hit_pulse(4'b0010);
        for (int k = 1; k <= 4; k++) begin
            next_frame();
            checks++; if (visible[1] !== exp_tab[k-1])
                $display("FAIL rearm_frame%0d got=%b exp=%b", k, visible[1], exp_tab[k-1]);
            else passed++;
        end
`ifdef OPERAND_HUD_BLINK_EN
        next_frame();
        checks++; if (visible[1] !== 1'b0) $display("FAIL rearm_blink0 got=%b exp=0", visible[1]); else passed++;
        hit_pulse(4'b0010);
        for (int k = 1; k <= rec_frames; k++) begin
            next_frame();
            checks++; if (visible[1] !== exp_tab[k-1])
                $display("FAIL blink_rehit_frame%0d got=%b exp=%b", k, visible[1], exp_tab[k-1]);
            else passed++;
        end
`endif
        checks++; if (visible !== 4'b1111) $display("FAIL rearm_done got=%b exp=1111", visible); else passed++;
    endtask

    task automatic test_simultaneous();
        tick(99);
        hit = 4'b0100;
        startOfFrame = 1'b1;
        tick(1);
        hit = '0;
        startOfFrame = 1'b0;
        checks++; if (visible !== 4'b1011) $display("FAIL simul_hide got=%b exp=1011", visible); else passed++;
        for (int k = 1; k <= rec_frames; k++) begin
            next_frame();
            checks++; if (visible[2] !== exp_tab[k-1])
                $display("FAIL simul_frame%0d got=%b exp=%b", k, visible[2], exp_tab[k-1]);
            else passed++;
        end
    endtask

    task automatic test_hidden_pixel();
        set_pixel(60, 440);
        hit_pulse(4'b1000);
        set_pixel(665, 445);
        checks++; if ({operandDR, anyDR} !== 5'b0)
            $display("FAIL hidden_dr got dr=%b any=%b exp 0/0", operandDR, anyDR);
        else passed++;
        checks++; if ({selIdx, offsetX, offsetY} !== {2'd0, 11'd10, 11'd10})
            $display("FAIL hidden_hold got sel=%0d ox=%0d oy=%0d exp 0/10/10", selIdx, offsetX, offsetY);
        else passed++;
        set_pixel(0, 0);
        for (int k = 1; k <= rec_frames; k++) next_frame();
        set_pixel(660, 440);
        checks++; if ({operandDR, anyDR} !== 5'b10001)
            $display("FAIL recovered_dr got dr=%b any=%b exp 1000/1", operandDR, anyDR);
        else passed++;
        checks++; if ({selIdx, offsetX, offsetY} !== {2'd3, 11'd10, 11'd10})
            $display("FAIL recovered_sel got sel=%0d ox=%0d oy=%0d exp 3/10/10", selIdx, offsetX, offsetY);
        else passed++;
        set_pixel(665, 445);
        checks++; if ({selIdx, offsetX, offsetY} !== {2'd3, 11'd15, 11'd15})
            $display("FAIL recovered_off got sel=%0d ox=%0d oy=%0d exp 3/15/15", selIdx, offsetX, offsetY);
        else passed++;
        set_pixel(0, 0);
    endtask

    task automatic test_reset_mid();
        hit_pulse(4'b0001);
        next_frame();
        checks++; if (visible !== 4'b1110) $display("FAIL mid_pre got=%b exp=1110", visible); else passed++;
        resetN = 1'b0;
        tick(1);
        resetN = 1'b1;
        tick(1);
        checks++; if (visible !== 4'b1111) $display("FAIL mid_release got=%b exp=1111", visible); else passed++;
        for (int k = 1; k <= 6; k++) begin
            next_frame();
            checks++; if (visible !== 4'b1111) $display("FAIL mid_frame%0d got=%b exp=1111", k, visible); else passed++;
        end
    endtask

    initial begin
`ifdef OPERAND_HUD_BLINK_EN
        exp_tab    = 8'b1110_0000;
        rec_frames = 8;
`else
        exp_tab    = 8'b0000_1000;
        rec_frames = 4;
`endif
        test_reset();
        test_region_edges();
        test_hit_timeout();
        test_rearm();
        test_simultaneous();
        test_hidden_pixel();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached, checks=%0d passed=%0d", checks, passed);
        $fatal(1);
    end

endmodule
